// File: rtl/usart_pkg.sv
// Shared definitions for the my_usart transmitter/receiver pair:
// receiver state encoding, default frame geometry and a counter-width helper.
package usart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam int USART_OVERSAMPLE = 16;
    localparam int USART_DATA_BITS  = 8;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int usart_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Both flops reset to 1 so a line held idle never looks like a start edge.
module usart_sync2 (
    input  logic clock_devided,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock_devided) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/my_usart_rx.sv
// 8N1 UART receiver clocked at OVERSAMPLE x baud; delivers bytes with a
// valid/ack handshake and flags false starts, framing errors and overruns.
module my_usart_rx
    import usart_pkg::*;
#(
    parameter int OVERSAMPLE = USART_OVERSAMPLE,
    parameter int DATA_BITS  = USART_DATA_BITS
) (
    input  logic                 clock_devided,
    input  logic                 reset,
    input  logic                 rx_pin,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int TICK_W = usart_cnt_w(OVERSAMPLE);
    localparam int BIT_W  = usart_cnt_w(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    logic rxs;

    rx_state_e            state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 ferr_q, ferr_d;

    logic                 accept;
    logic                 frame_bad;

    usart_sync2 u_sync_rx (
        .clock_devided (clock_devided),
        .reset         (reset),
        .async_i       (rx_pin),
        .sync_o        (rxs)
    );

    always_ff @(posedge clock_devided) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Start bit is checked at its midpoint; every later bit one full period on.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        accept    = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            RX_IDLE: begin
                tick_d = '0;
                if (!rxs) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                tick_d = tick_q + TICK_ONE;
                if (tick_q == TICK_MID) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                tick_d = tick_q + TICK_ONE;
                if (tick_q == TICK_LAST) begin
                    tick_d         = '0;
                    shift_d[bit_q] = rxs;
                    if (bit_q == BIT_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
            RX_STOP: begin
                tick_d = tick_q + TICK_ONE;
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (rxs) begin
                        accept  = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        shift_d   = '0;
                        state_d   = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                tick_d = '0;
                if (rxs) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    // An ack landing on the accept cycle frees the holding register for the new byte.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = frame_bad;
        if (accept) begin
            if (!valid_q || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_busy       = (state_q != RX_IDLE);
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_my_usart_rx.sv
// Bench for my_usart_rx: frame table, timing/corner sequences, and random
// frames checked against a byte-level handshake model.
module tb_my_usart_rx;

    localparam int OS = 16;
    localparam int DB = 8;

    logic       clock_devided = 1'b0;
    logic       reset         = 1'b0;
    logic       rx_pin        = 1'b1;
    logic       rx_ack        = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       framing_error;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    bit line_q[$];
    bit ack_q[$];

    logic [7:0] h_data  [0:1023];
    logic       h_valid [0:1023];
    logic       h_busy  [0:1023];
    logic       h_ferr  [0:1023];
    logic       h_ovr   [0:1023];
    int         ferr_cnt;
    int         valid_cnt;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         ack_pre;
        logic [7:0] exp_data;
        bit         exp_valid;
        bit         exp_ovr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [7];

    my_usart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clock_devided (clock_devided),
        .reset         (reset),
        .rx_pin        (rx_pin),
        .rx_ack        (rx_ack),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_busy       (rx_busy),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clock_devided = ~clock_devided;

    task automatic tick();
        @(posedge clock_devided);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_level(input bit lvl, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(lvl);
    endtask

    task automatic add_frame(input logic [7:0] b, input bit stop);
        add_level(1'b0, OS);
        for (int k = 0; k < DB; k++) add_level(b[k], OS);
        add_level(stop, OS);
    endtask

    // Ack high during the line interval with the given index.
    task automatic set_ack(input int idx);
        while (ack_q.size() < idx) ack_q.push_back(1'b0);
        ack_q.push_back(1'b1);
    endtask

    // Level t is driven between edges E0+t and E0+t+1; h_*[t+1] is seen after edge E0+t+1.
    task automatic play();
        ferr_cnt  = 0;
        valid_cnt = 0;
        for (int t = 0; t < line_q.size(); t++) begin
            rx_pin = line_q[t];
            rx_ack = (t < ack_q.size()) ? ack_q[t] : 1'b0;
            tick();
            h_data[t+1]  = rx_data;
            h_valid[t+1] = rx_valid;
            h_busy[t+1]  = rx_busy;
            h_ferr[t+1]  = framing_error;
            h_ovr[t+1]   = overrun;
            ferr_cnt  += int'(framing_error);
            valid_cnt += int'(rx_valid);
        end
        rx_pin = 1'b1;
        rx_ack = 1'b0;
        line_q.delete();
        ack_q.delete();
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        rx_pin = 1'b1;
        rx_ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},  32'(rx_data), 32'h0);
        check({tag, "_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_busy"},  32'(rx_busy), 32'h0);
        check({tag, "_ferr"},  32'(framing_error), 32'h0);
        check({tag, "_ovr"},   32'(overrun), 32'h0);
    endtask

    initial begin
        logic [7:0] m_data;
        bit         m_valid;
        bit         m_ovr;
        bit         prev_bad;
        int         cnt;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 0};
        vecs[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 0};
        vecs[3] = '{8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 0};

        reset = 1'b0;
        tick();
        tick();
        tick();
        check_zero("reset");
        reset = 1'b1;
        tick();

        // Good frame with exact edge timing: D = E0+3, accept at D+152.
        add_frame(8'hA5, 1'b1);
        add_level(1'b1, 8);
        play();
        check("tim_busy_pre",   32'(h_busy[2]), 32'h0);
        check("tim_busy_rise",  32'(h_busy[3]), 32'h1);
        check("tim_busy_hold",  32'(h_busy[154]), 32'h1);
        check("tim_busy_fall",  32'(h_busy[155]), 32'h0);
        check("tim_valid_pre",  32'(h_valid[154]), 32'h0);
        check("tim_valid_edge", 32'(h_valid[155]), 32'h1);
        check("tim_data_edge",  32'(h_data[155]), 32'hA5);
        check("tim_ferr",       32'(ferr_cnt), 32'h0);
        check("tim_ovr",        32'(h_ovr[160]), 32'h0);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            add_level(1'b1, 2);
            if (vecs[i].ack_pre) set_ack(1);
            add_frame(vecs[i].data, vecs[i].stop);
            add_level(1'b1, 8);
            play();
            check($sformatf("vec%0d_data", i),  32'(rx_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ovr", i),   32'(overrun), 32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d_ferr", i),  32'(ferr_cnt), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_busy", i),  32'(rx_busy), 32'h0);
        end

        // False start: 4 low ticks, rejected at the D+8 mid-start sample.
        do_reset();
        add_level(1'b0, 4);
        add_level(1'b1, 30);
        play();
        check("fs_busy_rise", 32'(h_busy[3]), 32'h1);
        check("fs_busy_hold", 32'(h_busy[10]), 32'h1);
        check("fs_busy_fall", 32'(h_busy[11]), 32'h0);
        check("fs_valid",     32'(valid_cnt), 32'h0);
        check("fs_ferr",      32'(ferr_cnt), 32'h0);

        // Framing error followed by a 40-tick break.
        add_frame(8'h3C, 1'b0);
        add_level(1'b0, 40);
        add_level(1'b1, 30);
        play();
        check("fe_pulse_at",   32'(h_ferr[155]), 32'h1);
        check("fe_pulse_len",  32'(ferr_cnt), 32'h1);
        check("fe_busy_break", 32'(h_busy[202]), 32'h1);
        check("fe_busy_exit",  32'(h_busy[203]), 32'h0);
        cnt = 0;
        for (int t = 203; t <= 230; t++) cnt += int'(h_busy[t]);
        check("fe_no_spurious", 32'(cnt), 32'h0);
        check("fe_valid",       32'(valid_cnt), 32'h0);

        // Ack pulse lands exactly on the second frame's accept edge.
        do_reset();
        add_frame(8'h11, 1'b1);
        add_frame(8'h22, 1'b1);
        set_ack(160 + 154);
        add_level(1'b1, 6);
        play();
        check("co_data_pre",  32'(h_data[314]), 32'h11);
        check("co_valid_pre", 32'(h_valid[314]), 32'h1);
        check("co_data",      32'(h_data[315]), 32'h22);
        check("co_valid",     32'(h_valid[315]), 32'h1);
        check("co_ovr",       32'(h_ovr[315]), 32'h0);

        // Build up valid+overrun, then reset during bit 4 of 8'hFF.
        add_frame(8'h33, 1'b1);
        add_level(1'b1, 4);
        play();
        check("rm_pre_ovr", 32'(overrun), 32'h1);
        add_level(1'b0, OS);
        add_level(1'b1, 4 * OS + 8);
        play();
        check("rm_pre_busy", 32'(rx_busy), 32'h1);
        reset = 1'b0;
        tick();
        check_zero("rm");
        reset = 1'b1;
        add_level(1'b1, 20);
        add_frame(8'h5A, 1'b1);
        add_level(1'b1, 4);
        play();
        check("rm_after_data",  32'(rx_data), 32'h5A);
        check("rm_after_valid", 32'(rx_valid), 32'h1);
        check("rm_after_ovr",   32'(overrun), 32'h0);

        // Random frames against a byte-level handshake model.
        do_reset();
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        prev_bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            bit         bad;
            bit         ack;
            int         gap;
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            ack = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 12) + (prev_bad ? 4 : 0);
            add_level(1'b1, gap);
            if (ack) begin
                set_ack(line_q.size());
                add_level(1'b1, 1);
            end
            add_frame(b, !bad);
            play();
            if (ack && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            if (!bad) begin
                if (!m_valid) begin
                    m_data  = b;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            check($sformatf("rnd%0d_data", i),  32'(rx_data), 32'(m_data));
            check($sformatf("rnd%0d_valid", i), 32'(rx_valid), 32'(m_valid));
            check($sformatf("rnd%0d_ovr", i),   32'(overrun), 32'(m_ovr));
            check($sformatf("rnd%0d_ferr", i),  32'(ferr_cnt), bad ? 32'h1 : 32'h0);
            prev_bad = bad;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
